// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over 16 requesters with a one-hot grant decode.
// A grant lasts until done, until the holder drops its request, or until
// HOLD_MAX cycles elapse (forced release, flagged by a one-cycle timeout).
// Every grant is followed by at least one idle cycle before the next one.
module decoder_rr_arbiter #(
   parameter int HOLD_MAX = 8  // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_vld,
   output logic        timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        to_q, to_d;

   logic        found;
   logic [3:0]  pick;
   logic [3:0]  cand;
   logic        hold_end;
   logic        grant_end;

   // Last cycle a holder may keep the resource, and any reason to release it.
   assign hold_end  = (cnt_q == 8'(HOLD_MAX - 1));
   assign grant_end = done | ~req[idx_q] | hold_end;

   // Find the first requester at or after ptr, wrapping 15 -> 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; that is what keeps latches from being inferred.
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state logic: issue grants from IDLE, release them from GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en && found) begin
               state_d = GRANT;
               idx_d   = pick;
               cnt_d   = 8'd0;
            end
         end
         GRANT: begin
            if (grant_end) begin
               state_d = IDLE;
               ptr_d   = idx_q + 4'd1;
               // Flag only a release forced purely by the hold limit.
               to_d    = hold_end & ~done & req[idx_q];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 4'd0;
         idx_q   <= 4'd0;
         cnt_q   <= 8'd0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   assign gnt_vld = (state_q == GRANT);
   assign gnt_idx = idx_q;
   assign timeout = to_q;
   assign gnt     = gnt_vld ? (16'h0001 << idx_q) : 16'h0000;

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, giving the maximum number of cycles one grant may last (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: arbitration enable; new grants are issued only while high.
REQ-005 The block SHALL have port req, input, 16 bits: request lines; req[i] is requester i.
REQ-006 The block SHALL have port done, input, 1 bit: the current grant holder releases the resource.
REQ-007 The block SHALL have port gnt, output, 16 bits: one-hot grant, the 4-to-16 decode of gnt_idx qualified by gnt_vld; all zero when no grant.
REQ-008 The block SHALL have port gnt_idx, output, 4 bits: index of the current grant holder.
REQ-009 The block SHALL have port gnt_vld, output, 1 bit: a grant is active.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and GRANT, with gnt_vld high exactly in GRANT.
REQ-012 The block SHALL hold a 4-bit round-robin pointer ptr, the index searched first.
REQ-013 In IDLE with en=1 and req!=0, the block SHALL select the first set req bit at or after ptr, searching upward with wrap 15->0, and SHALL enter GRANT on the next edge with gnt_idx set to that index (grant latency 1 cycle).
REQ-014 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with gnt=0.
REQ-015 In GRANT, gnt SHALL have exactly one bit set, bit gnt_idx; gnt_idx SHALL stay constant.
REQ-016 The grant SHALL end when done=1, when req[gnt_idx]=0, or when the hold counter reaches HOLD_MAX-1; the block SHALL return to IDLE on the next edge.
REQ-017 The hold counter (8 bits) SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-018 When the grant ends by the counter while done=0 and req[gnt_idx]=1, timeout SHALL pulse high for the first IDLE cycle only; it SHALL stay 0 when done or req drop ends the grant in the same cycle.
REQ-019 On the end of a grant, ptr SHALL load gnt_idx+1 modulo 16 (15 wraps to 0).
REQ-020 After each grant the block SHALL spend at least one cycle in IDLE with gnt=0 (no back-to-back grants).
REQ-021 Deasserting en during GRANT SHALL NOT preempt the current grant; only new grants are blocked.
REQ-022 Changes on req bits other than gnt_idx during GRANT SHALL have no effect until the next IDLE evaluation.

Reset
REQ-023 With rst=1 at a rising edge the block SHALL enter IDLE and clear ptr, hold counter, gnt, gnt_idx, gnt_vld and timeout to 0 on that edge, regardless of state.
REQ-024 rst SHALL take priority over en, req and done in the same cycle; a grant in progress is dropped without a timeout pulse.
REQ-025 From the first cycle after rst falls, the block SHALL arbitrate normally starting from ptr=0.

Verification
REQ-026 Reset, then en=1, req=16'h0001 -> one cycle later gnt=16'h0001, gnt_idx=0, gnt_vld=1; done=1 for one cycle -> gnt=0 next cycle, ptr=1.
REQ-027 Fairness: en=1, req=16'h8001 held, done pulsed each grant -> grants alternate idx 0, 15, 0, 15 with one idle cycle between each.
REQ-028 Wrap: ptr=15 (after a grant to 14), req=16'h0009 -> grant to idx 0, then idx 3.
REQ-029 Timeout: HOLD_MAX=8, req[5] held, done=0 -> gnt_vld high exactly 8 cycles, timeout=1 for one cycle, ptr=6.
REQ-030 Mid-grant controls: during a grant to idx 2, en=0 -> grant continues until done; then no new grant while en=0 even with req=16'hFFFF.
REQ-031 Reset mid-grant: rst=1 during GRANT with idx 9 -> next cycle gnt=0, gnt_vld=0, timeout=0; after release with req=16'h0600 -> grant to idx 9.
